// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, multi-cycle mult/div with busy countdown.
// Define MDU_DIV_EN to include the divider; otherwise div/divu decode as no-ops.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruc,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    output logic        start,
    output logic [4:0]  busyCnt,
    output logic [31:0] HLRe
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MDU_DIV_EN
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // Signed divide on magnitudes; quotient truncates toward zero, remainder follows dividend.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = a[31] ? (~$unsigned(a) + 32'd1) : $unsigned(a);
        mb = b[31] ? (~$unsigned(b) + 32'd1) : $unsigned(b);
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction
`endif

    logic [5:0]  funct;
    logic        is_r, is_mul, is_div, idle;
    logic        unused_fields;
    logic [31:0] hi, lo;

    assign funct         = instruc[5:0];
    assign is_r          = (instruc[31:26] == 6'd0);
    assign unused_fields = &{1'b0, instruc[25:6]};
    assign is_mul        = is_r && (funct == F_MULT || funct == F_MULTU);
`ifdef MDU_DIV_EN
    assign is_div        = is_r && (funct == F_DIV || funct == F_DIVU);
`else
    assign is_div        = 1'b0;
`endif
    assign idle  = (busyCnt == 5'd0);
    assign start = (is_mul || is_div) && idle;

    always_comb begin
        HLRe = 32'd0;
        if (is_r && funct == F_MFHI) HLRe = hi;
        if (is_r && funct == F_MFLO) HLRe = lo;
    end

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] res_hi, res_lo;
    logic               res_wr;

    assign prod_s = $signed({{32{MD_A[31]}}, MD_A}) * $signed({{32{MD_B[31]}}, MD_B});
    assign prod_u = {32'd0, MD_A} * {32'd0, MD_B};

    // funct[0] selects the unsigned variant, funct[1] selects divide
    always_comb begin
        res_hi = funct[0] ? prod_u[63:32] : prod_s[63:32];
        res_lo = funct[0] ? prod_u[31:0]  : prod_s[31:0];
        res_wr = 1'b1;
`ifdef MDU_DIV_EN
        if (funct[1]) begin
            {res_hi, res_lo} = funct[0] ? div_unsigned(MD_A, MD_B) : div_signed(MD_A, MD_B);
            res_wr = (MD_B != 32'd0);
        end
`endif
    end

    logic [31:0] pend_hi_p0, pend_lo_p0;
    logic        pend_vld_p0;

    // Issue stage: capture the pending result
    always_ff @(posedge clk) begin
        if (start) begin
            pend_hi_p0 <= res_hi;
            pend_lo_p0 <= res_lo;
        end
    end

    // Countdown and commit stage
    always_ff @(posedge clk) begin
        if (reset) begin
            busyCnt     <= 5'd0;
            pend_vld_p0 <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else if (!idle) begin
            busyCnt <= busyCnt - 5'd1;
            if (busyCnt == 5'd1 && pend_vld_p0) begin
                hi <= pend_hi_p0;
                lo <= pend_lo_p0;
            end
        end else if (start) begin
            busyCnt     <= is_div ? 5'd10 : 5'd5;
            pend_vld_p0 <= res_wr;
        end else if (is_r && funct == F_MTHI) begin
            hi <= MD_A;
        end else if (is_r && funct == F_MTLO) begin
            lo <= MD_A;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic HI/LO model.
// Honours MDU_DIV_EN the same way the design does.
module tb_mult_div_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruc, MD_A, MD_B;
    logic        start;
    logic [4:0]  busyCnt;
    logic [31:0] HLRe;

    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .instruc (instruc),
        .MD_A    (MD_A),
        .MD_B    (MD_B),
        .start   (start),
        .busyCnt (busyCnt),
        .HLRe    (HLRe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'd0, mid, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag);
        instruc = mk(6'h10);
        #1 check({tag, " hi"}, HLRe, m_hi);
        instruc = mk(6'h12);
        #1 check({tag, " lo"}, HLRe, m_lo);
        instruc = mk(6'h00);
        #1;
    endtask

    // Architectural result of one instruction; lat=0 means no multi-cycle operation starts
    task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] nh, output logic [31:0] nl,
                            output bit wr, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        nh = m_hi; nl = m_lo; wr = 1'b0; lat = 0;
        case (f)
            6'h18: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; wr = 1'b1; lat = 5; end
            6'h19: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; wr = 1'b1; lat = 5; end
            6'h1A: if (DIV_EN) begin
                lat = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; wr = 1'b1; end
            end
            6'h1B: if (DIV_EN) begin
                lat = 10;
                if (b != 0) begin q = ua / ub; r = ua % ub; nl = q[31:0]; nh = r[31:0]; wr = 1'b1; end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude);
        logic [31:0] nh, nl;
        bit          wr;
        int          lat;
        logic [5:0]  junk [6] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13};
        model_op(f, a, b, nh, nl, wr, lat);
        instruc = mk(f); MD_A = a; MD_B = b;
        #1 check({tag, " start"}, 32'(start), 32'(lat != 0));
        tick();
        instruc = mk(6'h00);
        if (f == 6'h11) m_hi = a;
        if (f == 6'h13) m_lo = a;
        check({tag, " busy"}, 32'(busyCnt), 32'(lat));
        for (int k = lat - 1; k >= 0; k--) begin
            check_hilo({tag, " during"});
            if (intrude) begin
                instruc = mk(junk[$urandom_range(0, 5)]);
                MD_A = $urandom; MD_B = $urandom;
                #1 check({tag, " start while busy"}, 32'(start), 32'd0);
            end
            tick();
            instruc = mk(6'h00);
            check({tag, " countdown"}, 32'(busyCnt), 32'(k));
        end
        if (wr) begin m_hi = nh; m_lo = nl; end
        check_hilo({tag, " after"});
    endtask

    initial begin
        logic [5:0]  ops [7] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10};
        logic [31:0] ra, rb;
        reset = 1'b1; instruc = 32'd0; MD_A = 32'd0; MD_B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1 check("reset busy", 32'(busyCnt), 32'd0);
        check("reset start", 32'(start), 32'd0);
        check_hilo("reset");

        run_op("mult", 6'h18, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult hi const", m_hi, 32'hFFFFFFFF);
        check("mult lo const", m_lo, 32'hFFFFFFFA);
        run_op("multu", 6'h19, 32'hFFFFFFFE, 32'd3, 1'b0);
        run_op("div", 6'h1A, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("divu", 6'h1B, 32'd7, 32'd2, 1'b0);
        run_op("mthi", 6'h11, 32'h11, 32'd0, 1'b0);
        run_op("mtlo", 6'h13, 32'h22, 32'd0, 1'b0);
        run_op("div0", 6'h1A, 32'h1234, 32'd0, 1'b0);
        check("div0 hi kept", m_hi, 32'h11);
        run_op("divovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("mult busy", 6'h18, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        run_op("mthi2", 6'h11, 32'hDEADBEEF, 32'd0, 1'b0);

        // Reset in the middle of a multiply discards the pending result
        instruc = mk(6'h18); MD_A = 32'd77; MD_B = 32'd99;
        tick();
        instruc = mk(6'h00);
        tick(); tick(); tick();
        check("pre-reset busy", 32'(busyCnt), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("midop reset busy", 32'(busyCnt), 32'd0);
        check_hilo("midop reset");
        repeat (6) tick();
        check_hilo("no late commit");

        // Non-zero opcode with a mult/mfhi funct must be ignored
        instruc = {6'h23, 20'd0, 6'h18}; MD_A = 32'd5; MD_B = 32'd6;
        #1 check("opcode start", 32'(start), 32'd0);
        tick();
        instruc = {6'h23, 20'd0, 6'h10};
        #1 check("opcode busy", 32'(busyCnt), 32'd0);
        check("opcode HLRe", HLRe, 32'd0);
        instruc = mk(6'h00);
        check_hilo("opcode");

        for (int i = 0; i < 60; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = -ra;
                default: ;
            endcase
            run_op("rand", ops[$urandom_range(0, 6)], ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
